bla_sub_pipe: RTL

- Pipelined WIDTH-bit subtractor computing diff = a - b - bin.
- Built from 4-bit borrow-lookahead slices, with one slice resolved per pipeline stage. It is the subtract-direction counterpart of the team's 4-bit carry-lookahead adder.
- Valid/ready handshakes on both sides so it can sit in a datapath with backpressure. Sustained throughput is 1 result per cycle.

---
 rtl/bla_sub_pipe.sv | 137 +++++++++++++
 1 files changed

// File: rtl/bla_sub_pipe.sv
// rtl/bla_sub_pipe.sv - pipelined borrow-lookahead subtractor (diff = a - b - bin), one 4-bit slice per stage
// Optional saturation on signed overflow: define BLA_SUB_SAT_EN.
module bla_sub_pipe #(
  parameter int STAGES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*STAGES-1:0] a,
  input  logic [4*STAGES-1:0] b,
  input  logic                bin,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*STAGES-1:0] diff,
  output logic                bout,
  output logic                ovf,
  output logic                zero
);

  localparam int W = 4 * STAGES;
  localparam int L = STAGES - 1;

  // Returns {borrow-out, 4-bit difference}; all borrows in two-level lookahead form.
  function automatic logic [4:0] bla4(input logic [3:0] x, input logic [3:0] y, input logic bi);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:1] br;
    g     = ~x & y;
    p     = ~(x ^ y);
    br[1] = g[0] | (p[0] & bi);
    br[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bi);
    br[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & bi);
    br[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
          | (p[3] & p[2] & p[1] & p[0] & bi);
    return {br[4], x ^ y ^ {br[3:1], bi}};
  endfunction

  logic         v_q  [STAGES];
  logic [W-1:0] a_q  [STAGES];
  logic [W-1:0] b_q  [STAGES];
  logic [W-1:0] d_q  [STAGES];
  logic         br_q [STAGES];
  logic         z_q  [STAGES];

  logic         v_d  [STAGES];
  logic [W-1:0] a_d  [STAGES];
  logic [W-1:0] b_d  [STAGES];
  logic [W-1:0] d_d  [STAGES];
  logic         br_d [STAGES];
  logic         z_d  [STAGES];

  logic [STAGES-1:0] adv;

  // A stage may load when everything downstream of it can move or it is empty.
  always_comb begin
    logic run;
    adv = '0;
    run = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      run    = run | ~v_q[k];
      adv[k] = run;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [W-1:0] src_a;
    logic [W-1:0] src_b;
    logic [W-1:0] src_d;
    logic         src_br;
    logic         src_z;
    logic         src_v;
    logic [4:0]   slice;

    if (k == 0) begin : g_first
      assign src_a  = a;
      assign src_b  = b;
      assign src_d  = '0;
      assign src_br = bin;
      assign src_z  = 1'b1;
      assign src_v  = in_valid;
    end else begin : g_next
      assign src_a  = a_q[k-1];
      assign src_b  = b_q[k-1];
      assign src_d  = d_q[k-1];
      assign src_br = br_q[k-1];
      assign src_z  = z_q[k-1];
      assign src_v  = v_q[k-1];
    end

    assign slice   = bla4(src_a[4*k +: 4], src_b[4*k +: 4], src_br);
    assign v_d[k]  = src_v;
    assign a_d[k]  = src_a;
    assign b_d[k]  = src_b;
    assign d_d[k]  = src_d | (W'(slice[3:0]) << (4 * k));
    assign br_d[k] = slice[4];
    assign z_d[k]  = src_z & (slice[3:0] == 4'h0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k]  <= 1'b0;
        a_q[k]  <= '0;
        b_q[k]  <= '0;
        d_q[k]  <= '0;
        br_q[k] <= 1'b0;
        z_q[k]  <= 1'b0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (adv[k]) begin
          v_q[k]  <= v_d[k];
          a_q[k]  <= a_d[k];
          b_q[k]  <= b_d[k];
          d_q[k]  <= d_d[k];
          br_q[k] <= br_d[k];
          z_q[k]  <= z_d[k];
        end
      end
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = v_q[L];
  assign bout      = br_q[L];
  assign zero      = z_q[L];
  assign ovf       = (a_q[L][W-1] ^ b_q[L][W-1]) & (d_q[L][W-1] ^ a_q[L][W-1]);

`ifdef BLA_SUB_SAT_EN
  // Negative minuend can only overflow downward, so its msb picks the rail.
  assign diff = ovf ? {a_q[L][W-1], {(W-1){~a_q[L][W-1]}}} : d_q[L];
`else
  assign diff = d_q[L];
`endif

endmodule
